// File: rtl/imm_gen_pipe.sv
// imm_gen_pipe: pipelined immediate generator for the decode stage.
// Decodes the immediate format from the opcode of a 32-bit instruction word,
// sign-extends the immediate to XLEN and presents it, with a format code and
// the original word, on a registered valid/ready output.
// Optional feature macro: IMM_GEN_CSR_EN (CSR zimm decode, fmt code 6).
// Ports:
//   clk, reset          clock, asynchronous active-high reset
//   flush               synchronous flush of all buffered entries
//   in_valid/in_ready   input handshake, in_inst = instruction word
//   out_valid/out_ready output handshake
//   out_imm             extended immediate (XLEN bits)
//   out_fmt             0 NONE, 1 I, 2 S, 3 B, 4 U, 5 J, 6 CSR
//   out_inst            instruction word passed through
module imm_gen_pipe #(
  parameter int unsigned XLEN = 32,
  parameter int unsigned SKID = 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_inst,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_imm,
  output logic [2:0]      out_fmt,
  output logic [31:0]     out_inst
);

  localparam logic [2:0] FMT_NONE = 3'd0;
  localparam logic [2:0] FMT_I    = 3'd1;
  localparam logic [2:0] FMT_S    = 3'd2;
  localparam logic [2:0] FMT_B    = 3'd3;
  localparam logic [2:0] FMT_U    = 3'd4;
  localparam logic [2:0] FMT_J    = 3'd5;
`ifdef IMM_GEN_CSR_EN
  localparam logic [2:0] FMT_CSR  = 3'd6;
`endif

  typedef enum logic [1:0] {ST_EMPTY, ST_ONE, ST_TWO} state_t;

  state_t            state, state_nxt;
  logic              load_out, load_skid, move_skid;
  logic              acc, drn;
  logic              rdy_q;
  logic [31:0]       dec_imm32;
  logic [2:0]        dec_fmt;
  logic [XLEN-1:0]   dec_imm;
  logic [XLEN-1:0]   skid_imm;
  logic [2:0]        skid_fmt;
  logic [31:0]       skid_inst;

  assign acc = in_valid && in_ready;
  assign drn = out_valid && out_ready;

  // rdy_q is low in reset and for the first cycle after; it gates in_ready in both modes
  assign in_ready = (SKID != 0) ? rdy_q : (rdy_q && (!out_valid || out_ready));

  // Immediate decode: build a 32-bit immediate, then sign-extend from bit 31
  always_comb begin
    dec_imm32 = 32'd0;
    dec_fmt   = FMT_NONE;
    case (in_inst[6:0])
      7'b0010011, 7'b0000011, 7'b1100111: begin
        dec_fmt   = FMT_I;
        dec_imm32 = {{20{in_inst[31]}}, in_inst[31:20]};
      end
      7'b0011011: begin
        if (XLEN == 64) begin
          dec_fmt   = FMT_I;
          dec_imm32 = {{20{in_inst[31]}}, in_inst[31:20]};
        end
      end
      7'b0100011: begin
        dec_fmt   = FMT_S;
        dec_imm32 = {{20{in_inst[31]}}, in_inst[31:25], in_inst[11:7]};
      end
      7'b1100011: begin
        dec_fmt   = FMT_B;
        dec_imm32 = {{19{in_inst[31]}}, in_inst[31], in_inst[7],
                     in_inst[30:25], in_inst[11:8], 1'b0};
      end
      7'b0110111, 7'b0010111: begin
        dec_fmt   = FMT_U;
        dec_imm32 = {in_inst[31:12], 12'd0};
      end
      7'b1101111: begin
        dec_fmt   = FMT_J;
        dec_imm32 = {{11{in_inst[31]}}, in_inst[31], in_inst[19:12],
                     in_inst[20], in_inst[30:21], 1'b0};
      end
`ifdef IMM_GEN_CSR_EN
      7'b1110011: begin
        // zimm is zero-extended: bit 31 of the 32-bit form is always 0 here
        if (in_inst[14]) begin
          dec_fmt   = FMT_CSR;
          dec_imm32 = {27'd0, in_inst[19:15]};
        end
      end
`endif
      default: begin
        dec_fmt   = FMT_NONE;
        dec_imm32 = 32'd0;
      end
    endcase
  end

  assign dec_imm = XLEN'($signed(dec_imm32));

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_EMPTY;
    else       state <= state_nxt;
  end

  // Next state and datapath steering; TWO is unreachable when SKID=0
  always_comb begin
    state_nxt = state;
    load_out  = 1'b0;
    load_skid = 1'b0;
    move_skid = 1'b0;
    case (state)
      ST_EMPTY: begin
        if (acc) begin
          state_nxt = ST_ONE;
          load_out  = 1'b1;
        end
      end
      ST_ONE: begin
        if (acc && !drn) begin
          state_nxt = ST_TWO;
          load_skid = 1'b1;
        end else if (!acc && drn) begin
          state_nxt = ST_EMPTY;
        end else if (acc && drn) begin
          load_out  = 1'b1;
        end
      end
      ST_TWO: begin
        if (drn) begin
          state_nxt = ST_ONE;
          move_skid = 1'b1;
        end
      end
      default: state_nxt = ST_EMPTY;
    endcase
    // flush discards the offered word and any drain; payload registers keep their values
    if (flush) begin
      state_nxt = ST_EMPTY;
      load_out  = 1'b0;
      load_skid = 1'b0;
      move_skid = 1'b0;
    end
  end

  // Output register, skid entry and ready flag
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_imm   <= '0;
      out_fmt   <= FMT_NONE;
      out_inst  <= 32'd0;
      skid_imm  <= '0;
      skid_fmt  <= FMT_NONE;
      skid_inst <= 32'd0;
      rdy_q     <= 1'b0;
    end else begin
      out_valid <= (state_nxt != ST_EMPTY);
      rdy_q     <= (SKID != 0) ? (state_nxt != ST_TWO) : 1'b1;
      if (load_out) begin
        out_imm  <= dec_imm;
        out_fmt  <= dec_fmt;
        out_inst <= in_inst;
      end else if (move_skid) begin
        out_imm  <= skid_imm;
        out_fmt  <= skid_fmt;
        out_inst <= skid_inst;
      end
      if (load_skid) begin
        skid_imm  <= dec_imm;
        skid_fmt  <= dec_fmt;
        skid_inst <= in_inst;
      end
    end
  end

endmodule

// File: doc/imm_gen_pipe.md
Name: imm_gen_pipe

Overview:
Parametrised, pipelined immediate generator for the decode stage.
- Accepts a 32-bit instruction word over a valid/ready handshake.
- Decodes the immediate format from the opcode and sign-extends the immediate to XLEN.
- Presents the immediate, a format code and the instruction word on a registered, back-pressurable output.
- Covers I, S, B, U and J formats, with optional CSR-immediate support.
- Sits between fetch/IF-ID and the ID-EX register.

Parameters:
XLEN, 32, datapath width; legal values are 32 and 64.
SKID, 1, 1 = two-entry skid buffer (full throughput under back-pressure); 0 = single output register.

Ports:
clk  input  1  clock; all state changes on its rising edge.
reset  input  1  asynchronous, active-high reset.
flush  input  1  synchronous pipeline flush.
in_valid  input  1  instruction word present.
in_ready  output  1  block can accept a word this cycle.
in_inst  input  32  instruction word.
out_valid  output  1  output entry valid.
out_ready  input  1  consumer accepts the output entry.
out_imm  output  XLEN  sign- or zero-extended immediate.
out_fmt  output  3  format code: 0 NONE, 1 I, 2 S, 3 B, 4 U, 5 J, 6 CSR.
out_inst  output  32  instruction word passed through with the immediate.

Behaviour:
- Clock and reset: one clock, clk. reset is asynchronous and active-high.
- While reset is asserted: out_valid=0, out_imm=0, out_fmt=0, out_inst=0, skid entry empty, in_ready=0.
- in_ready rises the first cycle after reset deasserts.
- Transfer rules: input transfer when in_valid && in_ready; output transfer when out_valid && out_ready.
- Latency: an accepted word appears on the output the next cycle, registered; no combinational path from in_inst to out_*.
- Format decode on opcode in_inst[6:0]:
  - 0010011, 0000011, 1100111 -> I. Imm = inst[31:20], sign-extended.
  - 0011011 -> I only when XLEN=64; otherwise NONE.
  - 0100011 -> S. Imm = {inst[31:25], inst[11:7]}, sign-extended.
  - 1100011 -> B. Imm = {inst[31], inst[7], inst[30:25], inst[11:8], 0}, sign-extended.
  - 0110111, 0010111 -> U. Imm = {inst[31:12], 12'b0}, sign-extended to XLEN (bit 31 replicated when XLEN=64).
  - 1101111 -> J. Imm = {inst[31], inst[19:12], inst[20], inst[30:21], 0}, sign-extended.
  - All other opcodes -> NONE, imm=0.
- No funct7/funct3-based modification of I-type immediates: the immediate is never negated.
- Sign extension always replicates inst[31] to bit XLEN-1.
- SKID=1 (states EMPTY, ONE, TWO):
  - EMPTY: accept -> ONE.
  - ONE: accept without drain -> TWO (word held in skid). Drain without accept -> EMPTY. Both -> ONE.
  - TWO: in_ready=0. Drain -> ONE, skid entry moves to output.
  - in_ready = !(state==TWO), registered.
- SKID=0: in_ready = !out_valid || out_ready.
- Ordering is strictly FIFO.
- Output hold: out_* are held stable while out_valid && !out_ready.
- Flush: clears all entries next cycle (out_valid=0, skid empty). Flush dominates a simultaneous accept, which is discarded, and a simultaneous drain. out_imm, out_fmt and out_inst keep their last values; they are don't-care while out_valid=0.
- Reset mid-operation: all entries are lost immediately and asynchronously.

Optional Feature:
IMM_GEN_CSR_EN.
- Defined: opcode 1110011 with funct3[2]=1 -> fmt CSR; imm = inst[19:15], zero-extended to XLEN.
- Defined: opcode 1110011 with funct3[2]=0 -> NONE, imm=0.
- Undefined: opcode 1110011 always decodes as NONE with imm=0, and fmt code 6 is never produced.

Test Plan:
- XLEN=32, back-to-back inputs 0xFFF00093, 0xFE112E23, 0x123452B7, 0xFF9FF06F with out_ready=1 -> one output per cycle, 1-cycle latency:
  - 0xFFFFFFFF fmt1
  - 0xFFFFFFFC fmt2
  - 0x12345000 fmt4
  - 0xFFFFFFF8 fmt5
- 0x40008093 (addi x1,x1,0x400) -> imm 0x00000400, fmt1; no negation.
- XLEN=64, 0xFE000EE3 (beq x0,x0,-4) -> imm 0xFFFFFFFFFFFFFFFC, fmt3. Input 0x800002B7 -> 0xFFFFFFFF80000000, fmt4.
- SKID=1 back-pressure: out_ready=0, offer three words -> two accepted, in_ready=0 on the third, out_* held stable. Raising out_ready drains the words in order with no loss or duplication.
- flush asserted while state TWO and in_valid=1 -> next cycle out_valid=0, the offered word is dropped, and the next accepted word emerges normally.
- reset asserted asynchronously mid-stream -> out_valid=0 and in_ready=0 within the same cycle. With IMM_GEN_CSR_EN defined, 0x0000D073 (csrrwi x0,0,1) -> imm 1, fmt6; with the macro undefined -> imm 0, fmt0.
